// File: rtl/retospect_loader_pkg.sv
// Shared types and constants for the neurochip configuration-chain loader.
package retospect_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    ARM,
    DONE
  } loader_state_t;

  localparam int CNB_CFG_BITS      = 19;
  localparam int CLKBOX_CFG_BITS   = 48;
  localparam int DEFAULT_CHAIN_LEN = CLKBOX_CFG_BITS + 50 * CNB_CFG_BITS;

endpackage

// File: rtl/retospect_piso8.sv
// 8-bit load/shift register with a down-counting bit count; serial input enters at the MSB
// so the same block serves as the transmit PISO and as the readback SIPO.
module retospect_piso8 (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_load,
  input  logic       i_shift,
  input  logic       i_ser,
  input  logic [7:0] i_data,
  input  logic [3:0] i_count,
  output logic [7:0] o_q,
  output logic [3:0] o_count
);

  logic [7:0] r_q;
  logic [3:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q     <= '0;
      r_count <= '0;
    end else if (i_load) begin
      r_q     <= i_data;
      r_count <= i_count;
    end else if (i_shift) begin
      r_q     <= {i_ser, r_q[7:1]};
      r_count <= r_count - 4'd1;
    end
  end

  assign o_q     = r_q;
  assign o_count = r_count;

endmodule

// File: rtl/retospect_bitstream_loader.sv
// Byte-fed serialiser for the neurochip config chain: shifts CHAIN_LEN bits LSB-first, then
// pulses chain_rst_nn once. Define LOADER_READBACK_EN to capture chain_ret into rb_data/rb_valid.
module retospect_bitstream_loader
  import retospect_loader_pkg::*;
#(
  parameter int CHAIN_LEN = DEFAULT_CHAIN_LEN,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       chain_cfg_en,
  output logic       chain_bs,
  input  logic       chain_ret,
  output logic       chain_rst_nn,
  output logic       busy,
  output logic       done,
  output logic [7:0] rb_data,
  output logic       rb_valid
);

  localparam logic [CNT_W-1:0] LP_LEN = CNT_W'(CHAIN_LEN);

  loader_state_t    r_state;
  logic [CNT_W-1:0] r_remaining;
  logic             r_in_ready, r_cfg_en, r_bs, r_rst_nn, r_busy, r_done;

  logic       w_start_ok, w_handshake, w_shift_ok;
  logic [3:0] w_chunk, w_tx_cnt;
  logic [7:0] w_tx_q;

  assign w_start_ok  = start && !abort && (r_state == IDLE || r_state == DONE);
  assign w_handshake = (r_state == LOAD) && in_valid && r_in_ready && !abort;
  assign w_shift_ok  = (r_state == SHIFT) && !abort;
  assign w_chunk     = (r_remaining >= CNT_W'(8)) ? 4'd8 : r_remaining[3:0];

  retospect_piso8 u_tx (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_handshake),
    .i_shift (w_shift_ok),
    .i_ser   (1'b0),
    .i_data  (in_data),
    .i_count (w_chunk),
    .o_q     (w_tx_q),
    .o_count (w_tx_cnt)
  );

  // Outputs are computed from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_remaining <= '0;
      r_in_ready  <= 1'b0;
      r_cfg_en    <= 1'b0;
      r_bs        <= 1'b0;
      r_rst_nn    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_rst_nn <= 1'b0;
      if (abort && (r_state == LOAD || r_state == SHIFT || r_state == ARM)) begin
        r_state    <= IDLE;
        r_in_ready <= 1'b0;
        r_cfg_en   <= 1'b0;
        r_bs       <= 1'b0;
        r_busy     <= 1'b0;
        r_done     <= 1'b0;
      end else begin
        unique case (r_state)
          IDLE, DONE: begin
            if (w_start_ok) begin
              r_state     <= LOAD;
              r_remaining <= LP_LEN;
              r_in_ready  <= 1'b1;
              r_busy      <= 1'b1;
              r_done      <= 1'b0;
            end
          end
          LOAD: begin
            if (w_handshake) begin
              r_state    <= SHIFT;
              r_in_ready <= 1'b0;
              r_cfg_en   <= 1'b1;
              r_bs       <= in_data[0];
            end
          end
          SHIFT: begin
            r_remaining <= r_remaining - 1'b1;
            if (w_tx_cnt == 4'd1) begin
              r_cfg_en <= 1'b0;
              r_bs     <= 1'b0;
              if (r_remaining == CNT_W'(1)) begin
                r_state  <= ARM;
                r_rst_nn <= 1'b1;
              end else begin
                r_state    <= LOAD;
                r_in_ready <= 1'b1;
              end
            end else begin
              r_bs <= w_tx_q[1];
            end
          end
          ARM: begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign in_ready     = r_in_ready;
  assign chain_cfg_en = r_cfg_en;
  assign chain_bs     = r_bs;
  assign chain_rst_nn = r_rst_nn;
  assign busy         = r_busy;
  assign done         = r_done;

  logic w_unused_tx;
  assign w_unused_tx = ^{w_tx_q[7:2], w_tx_q[0]};

`ifdef LOADER_READBACK_EN
  logic [7:0] r_rb_data, w_rb_q, w_rb_next;
  logic [3:0] w_rb_cnt;
  logic       r_rb_valid, w_rb_last, w_rb_load;

  // A readback byte closes on its 8th bit or on the chain's final bit, whichever comes first.
  assign w_rb_last = (w_rb_cnt == 4'd1) || (r_remaining == CNT_W'(1));
  assign w_rb_load = w_start_ok || (w_shift_ok && w_rb_last);
  assign w_rb_next = {chain_ret, w_rb_q[7:1]};

  retospect_piso8 u_rb (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_rb_load),
    .i_shift (w_shift_ok),
    .i_ser   (chain_ret),
    .i_data  (8'h00),
    .i_count (4'd8),
    .o_q     (w_rb_q),
    .o_count (w_rb_cnt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rb_data  <= '0;
      r_rb_valid <= 1'b0;
    end else begin
      r_rb_valid <= 1'b0;
      if (w_shift_ok && w_rb_last) begin
        r_rb_valid <= 1'b1;
        r_rb_data  <= w_rb_next >> (w_rb_cnt - 4'd1);
      end
    end
  end

  assign rb_data  = r_rb_data;
  assign rb_valid = r_rb_valid;
`else
  logic w_unused_ret;
  assign w_unused_ret = chain_ret;
  assign rb_data      = 8'h00;
  assign rb_valid     = 1'b0;
`endif

endmodule

// File: tb/tb_retospect_bitstream_loader.sv
// Directed bench: three loaders (CHAIN_LEN 12, 16 and default) share clock, reset and data.
module tb_retospect_bitstream_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, in_valid, abort;
  logic       start_s, start_r, start_f;
  logic [7:0] in_data;
  logic [1:0] sel;
  int         n_pass, n_total;

  logic       s_ready, s_cfg, s_bs, s_rst, s_busy, s_done, s_rbv;
  logic       r_ready, r_cfg, r_bs, r_rst, r_busy, r_done, r_rbv;
  logic       f_ready, f_cfg, f_bs, f_rst, f_busy, f_done, f_rbv;
  logic [7:0] s_rbd, r_rbd, f_rbd;

  logic [11:0]  s_chain;
  logic [15:0]  rb_chain;
  logic [997:0] f_chain;
  int s_cfg_cnt = 0, r_cfg_cnt = 0, f_cfg_cnt = 0;
  int s_rst_cnt = 0, r_rst_cnt = 0, f_rst_cnt = 0;
  int ovl_cnt = 0, rb_cnt = 0;
  logic [7:0] rb_first, rb_second;

  retospect_bitstream_loader #(.CHAIN_LEN(12)) u_small (
    .clk(clk), .reset(reset), .start(start_s), .abort(abort && sel == 2'd0),
    .in_data(in_data), .in_valid(in_valid && sel == 2'd0), .in_ready(s_ready),
    .chain_cfg_en(s_cfg), .chain_bs(s_bs), .chain_ret(1'b0), .chain_rst_nn(s_rst),
    .busy(s_busy), .done(s_done), .rb_data(s_rbd), .rb_valid(s_rbv)
  );

  retospect_bitstream_loader #(.CHAIN_LEN(998)) u_full (
    .clk(clk), .reset(reset), .start(start_f), .abort(abort && sel == 2'd1),
    .in_data(in_data), .in_valid(in_valid && sel == 2'd1), .in_ready(f_ready),
    .chain_cfg_en(f_cfg), .chain_bs(f_bs), .chain_ret(1'b0), .chain_rst_nn(f_rst),
    .busy(f_busy), .done(f_done), .rb_data(f_rbd), .rb_valid(f_rbv)
  );

  retospect_bitstream_loader #(.CHAIN_LEN(16)) u_rb (
    .clk(clk), .reset(reset), .start(start_r), .abort(abort && sel == 2'd2),
    .in_data(in_data), .in_valid(in_valid && sel == 2'd2), .in_ready(r_ready),
    .chain_cfg_en(r_cfg), .chain_bs(r_bs), .chain_ret(rb_chain[0]), .chain_rst_nn(r_rst),
    .busy(r_busy), .done(r_done), .rb_data(r_rbd), .rb_valid(r_rbv)
  );

  // Chain models: a bit enters at the top on each config_en edge and leaves from bit 0.
  always @(posedge clk) begin
    if (reset) begin
      s_chain  <= '0;
      rb_chain <= 16'hC33C;
      f_chain  <= '0;
      rb_cnt   <= 0;
    end else begin
      if (s_cfg) s_chain <= {s_bs, s_chain[11:1]};
      if (r_cfg) rb_chain <= {r_bs, rb_chain[15:1]};
      if (f_cfg) f_chain <= {f_bs, f_chain[997:1]};
      if (r_rbv) begin
        rb_cnt <= rb_cnt + 1;
        if (rb_cnt == 0) rb_first <= r_rbd;
        else             rb_second <= r_rbd;
      end
    end
    s_cfg_cnt <= s_cfg_cnt + int'(s_cfg);
    r_cfg_cnt <= r_cfg_cnt + int'(r_cfg);
    f_cfg_cnt <= f_cfg_cnt + int'(f_cfg);
    s_rst_cnt <= s_rst_cnt + int'(s_rst);
    r_rst_cnt <= r_rst_cnt + int'(r_rst);
    f_rst_cnt <= f_rst_cnt + int'(f_rst);
    ovl_cnt   <= ovl_cnt + int'(s_cfg & s_rst) + int'(r_cfg & r_rst) + int'(f_cfg & f_rst);
  end

  logic w_ready, w_done;
  always_comb begin
    w_ready = s_ready;
    w_done  = s_done;
    if (sel == 2'd1) begin
      w_ready = f_ready;
      w_done  = f_done;
    end else if (sel == 2'd2) begin
      w_ready = r_ready;
      w_done  = r_done;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start_s = (sel == 2'd0);
    start_f = (sel == 2'd1);
    start_r = (sel == 2'd2);
    @(negedge clk);
    start_s = 1'b0;
    start_f = 1'b0;
    start_r = 1'b0;
  endtask

  // Presents a byte and returns just after the handshake edge.
  task automatic send_byte(input logic [7:0] b, input string tag);
    logic ok;
    ok = 1'b0;
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (w_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) @(posedge clk);
    #1 in_valid = 1'b0;
    check(tag, 32'(ok), 32'd1);
  endtask

  task automatic wait_ready(input string tag);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (w_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  task automatic wait_done(input string tag);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (w_done) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  logic [7:0]   bytes [125];
  logic [997:0] exp_bits;
  int           base_cfg, base_rst, errs;

  initial begin
    n_pass = 0; n_total = 0;
    reset = 1'b1; in_valid = 1'b0; abort = 1'b0; in_data = 8'h00; sel = 2'd0;
    start_s = 1'b0; start_r = 1'b0; start_f = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_small_outs", 32'({s_ready, s_cfg, s_bs, s_rst, s_busy, s_done, s_rbv, s_rbd}), 32'd0);
    check("reset_full_outs",  32'({f_ready, f_cfg, f_bs, f_rst, f_busy, f_done, f_rbv, f_rbd}), 32'd0);
    reset = 1'b0;

    // in_valid while IDLE has no effect.
    in_data = 8'hFF; in_valid = 1'b1;
    repeat (4) @(negedge clk);
    check("idle_valid_ignored", 32'({s_ready, s_busy, s_cfg}), 32'd0);
    in_valid = 1'b0;

    // start and abort together in IDLE: abort wins.
    start_s = 1'b1; abort = 1'b1;
    @(negedge clk);
    start_s = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("start_abort_idle", 32'({s_busy, s_ready}), 32'd0);

    // CHAIN_LEN=12 with 0xA5, 0x0F and a 5-cycle gap before the second byte.
    pulse_start();
    check("load_entry", 32'({s_busy, s_ready, s_done, s_cfg}), 32'b1100);
    send_byte(8'hA5, "hs_a5");
    check("first_bit", 32'({s_cfg, s_bs}), 32'b11);
    wait_ready("reload_wait");
    check("bits_byte1", 32'(s_cfg_cnt), 32'd8);
    repeat (5) @(negedge clk);
    check("gap_no_shift", 32'({s_cfg, s_ready, s_busy}), 32'b011);
    check("gap_bits_held", 32'(s_cfg_cnt), 32'd8);
    send_byte(8'h0F, "hs_0f");
    wait_done("small_done");
    check("small_cfg_cycles", 32'(s_cfg_cnt), 32'd12);
    check("small_chain", 32'(s_chain), 32'hFA5);
    check("small_arm_pulses", 32'(s_rst_cnt), 32'd1);
    check("small_done_outs", 32'({s_done, s_busy, s_ready, s_rst, s_cfg}), 32'b10000);

    // Abort after three shifted bits; a simultaneous start is ignored.
    base_cfg = s_cfg_cnt; base_rst = s_rst_cnt;
    pulse_start();
    check("restart_clears_done", 32'({s_done, s_busy}), 32'b01);
    send_byte(8'hFF, "hs_abort");
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    abort = 1'b1; start_s = 1'b1;
    @(negedge clk);
    abort = 1'b0; start_s = 1'b0;
    check("abort_outs", 32'({s_busy, s_cfg, s_done, s_ready, s_rst}), 32'd0);
    check("abort_bits", 32'(s_cfg_cnt - base_cfg), 32'd3);
    repeat (3) @(negedge clk);
    check("abort_stays_idle", 32'(s_busy), 32'd0);
    check("abort_no_arm", 32'(s_rst_cnt - base_rst), 32'd0);

    // CHAIN_LEN=16 (no partial byte) against a chain preloaded with 0x3C, 0xC3.
    sel = 2'd2;
    pulse_start();
    send_byte(8'h11, "hs_rb1");
    send_byte(8'h22, "hs_rb2");
    wait_done("rb_done");
    check("rb_cfg_cycles", 32'(r_cfg_cnt), 32'd16);
    check("rb_chain", 32'(rb_chain), 32'h2211);
    check("rb_arm_pulses", 32'(r_rst_cnt), 32'd1);
`ifdef LOADER_READBACK_EN
    check("rb_count", 32'(rb_cnt), 32'd2);
    check("rb_byte0", 32'(rb_first), 32'h3C);
    check("rb_byte1", 32'(rb_second), 32'hC3);
`else
    check("rb_count_off", 32'(rb_cnt), 32'd0);
    check("rb_data_off", 32'(r_rbd), 32'd0);
`endif

    // Reset mid-shift on the default-length loader.
    sel = 2'd1;
    pulse_start();
    send_byte(8'h5A, "hs_pre_reset");
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 check("reset_mid_shift", 32'({f_cfg, f_bs, f_busy, f_ready, f_rst, f_done}), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Full-length load of 125 random bytes, with a start pulse while busy.
    base_cfg = f_cfg_cnt; base_rst = f_rst_cnt;
    pulse_start();
    for (int i = 0; i < 125; i++) begin
      bytes[i] = 8'($urandom);
      send_byte(bytes[i], "hs_full");
      if (i == 60) pulse_start();
    end
    wait_done("full_done");
    for (int i = 0; i < 998; i++) exp_bits[i] = bytes[i / 8][i % 8];
    errs = 0;
    for (int i = 0; i < 998; i++) if (f_chain[i] !== exp_bits[i]) errs++;
    check("full_cfg_cycles", 32'(f_cfg_cnt - base_cfg), 32'd998);
    check("full_chain_bits", 32'(errs), 32'd0);
    check("full_arm_pulses", 32'(f_rst_cnt - base_rst), 32'd1);
    check("full_done_outs", 32'({f_done, f_busy, f_cfg}), 32'b100);
    check("cfg_rst_overlap", 32'(ovl_cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
